// File: rtl/video_sig_gen.sv
// Raster timing generator: free-running h/v counters with registered sync,
// active-draw, new-frame and frame-count outputs, all cycle-aligned.
// Optional feature macro: VIDEO_SIG_GEN_DELAYED_EN adds hs/vs/ad outputs
// delayed by DELAY cycles to line up with the sprite stage.
module video_sig_gen #(
  parameter int unsigned ACTIVE_H = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned ACTIVE_V = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter int unsigned FPS      = 60,
  parameter int unsigned DELAY    = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
`ifdef VIDEO_SIG_GEN_DELAYED_EN
  output logic        hs_d_out,
  output logic        vs_d_out,
  output logic        ad_d_out,
`endif
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
);

  // H_TOTAL must stay <= 2048 and V_TOTAL <= 1024 to fit the count ports.
  localparam int unsigned H_TOTAL  = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = ACTIVE_V + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = ACTIVE_H + H_FP;
  localparam int unsigned HS_END   = ACTIVE_H + H_FP + H_SYNC;
  localparam int unsigned VS_START = ACTIVE_V + V_FP;
  localparam int unsigned VS_END   = ACTIVE_V + V_FP + V_SYNC;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [5:0]  FC_LAST = 6'(FPS - 1);

  logic        run_q;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ad_q, ad_d;
  logic        nf_q, nf_d;
  logic [5:0]  fc_q, fc_d;

  // Next raster position; holds at (0,0) on the start-up edge.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (run_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  // Flags decode the next position so they register alongside the counters.
  always_comb begin
    hs_d = (32'(hcount_d) >= HS_START) && (32'(hcount_d) < HS_END);
    vs_d = (32'(vcount_d) >= VS_START) && (32'(vcount_d) < VS_END);
    ad_d = (32'(hcount_d) < ACTIVE_H) && (32'(vcount_d) < ACTIVE_V);
    nf_d = (32'(hcount_d) == ACTIVE_H) && (32'(vcount_d) == ACTIVE_V);
    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 6'd1;
    end
  end

  // Timing state registers.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      run_q    <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
      fc_q     <= '0;
    end else begin
      run_q    <= 1'b1;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
      fc_q     <= fc_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;

`ifdef VIDEO_SIG_GEN_DELAYED_EN
  // Each stage holds {hs, vs, ad}; stage 0 takes the registered flags.
  logic [2:0] dly_q [DELAY];
  logic [2:0] dly_d [DELAY];

  // Shift the flag history one stage per pixel.
  always_comb begin
    dly_d[0] = {hs_q, vs_q, ad_q};
    for (int i = 1; i < DELAY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // Delay-line registers, cleared so the outputs read 0 after start-up.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DELAY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DELAY; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign hs_d_out = dly_q[DELAY-1][2];
  assign vs_d_out = dly_q[DELAY-1][1];
  assign ad_d_out = dly_q[DELAY-1][0];
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen using a small raster (12x8 total, FPS=3) so many
// frames and random asynchronous resets fit in a short run.
module tb_video_sig_gen;

  localparam int AH = 8, HFP = 1, HSY = 2, HBP = 1;
  localparam int AV = 4, VFP = 1, VSY = 2, VBP = 1;
  localparam int FPS = 3, DLY = 4;
  localparam int HT = AH + HFP + HSY + HBP;
  localparam int VT = AV + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int NF_T = AV * HT + AH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hs, vs, ad, nf;
  logic [5:0]  fc;
`ifdef VIDEO_SIG_GEN_DELAYED_EN
  logic        hs_dl, vs_dl, ad_dl;
`endif

  int checks = 0;
  int passed = 0;
  int e = 0;  // clock edges seen since reset release

  always #5 clk = ~clk;

  video_sig_gen #(
    .ACTIVE_H(AH), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .ACTIVE_V(AV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .FPS(FPS), .DELAY(DLY)
  ) dut (
    .pixel_clk_in(clk),
    .rst_n_in    (rst_n),
`ifdef VIDEO_SIG_GEN_DELAYED_EN
    .hs_d_out    (hs_dl),
    .vs_d_out    (vs_dl),
    .ad_d_out    (ad_dl),
`endif
    .hcount_out  (hcount),
    .vcount_out  (vcount),
    .hs_out      (hs),
    .vs_out      (vs),
    .ad_out      (ad),
    .nf_out      (nf),
    .fc_out      (fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at edge %0d: got %0h expected %0h", tag, e, obs, exp);
  endtask

  // Reference flags for pixel index t counted from the start-up edge.
  task automatic ref_flags(input int t, output bit r_hs, output bit r_vs, output bit r_ad);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    r_hs = (h >= AH + HFP) && (h < AH + HFP + HSY);
    r_vs = (v >= AV + VFP) && (v < AV + VFP + VSY);
    r_ad = (h < AH) && (v < AV);
  endtask

  task automatic check_all();
    int t, h, v, f, nfs;
    bit r_hs, r_vs, r_ad;
    if (e == 0) begin
      h = 0; v = 0; f = 0; nfs = 0;
      r_hs = 0; r_vs = 0; r_ad = 0;
    end else begin
      t = e - 1;
      h = t % HT;
      v = (t / HT) % VT;
      nfs = (t >= NF_T) ? (t - NF_T) / FT + 1 : 0;
      f = nfs % FPS;
      ref_flags(t, r_hs, r_vs, r_ad);
    end
    chk("hcount", 32'(hcount), 32'(h));
    chk("vcount", 32'(vcount), 32'(v));
    chk("hs", 32'(hs), 32'(r_hs));
    chk("vs", 32'(vs), 32'(r_vs));
    chk("ad", 32'(ad), 32'(r_ad));
    chk("nf", 32'(nf), 32'(e != 0 && h == AH && v == AV));
    chk("fc", 32'(fc), 32'(f));
`ifdef VIDEO_SIG_GEN_DELAYED_EN
    if (e - DLY >= 1) ref_flags(e - 1 - DLY, r_hs, r_vs, r_ad);
    else begin
      r_hs = 0; r_vs = 0; r_ad = 0;
    end
    chk("hs_d", 32'(hs_dl), 32'(r_hs));
    chk("vs_d", 32'(vs_dl), 32'(r_vs));
    chk("ad_d", 32'(ad_dl), 32'(r_ad));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) e++;
    #1;
    check_all();
  endtask

  // Assert reset between edges, check it took effect without a clock edge.
  task automatic async_reset(input int hold, input int offs);
    @(negedge clk);
    #offs;
    rst_n = 1'b0;
    e = 0;
    #1;
    check_all();
    repeat (hold) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    rst_n = 1'b1;
    // More than five frames: line/frame wraps, sync windows, fc wrap 2->0.
    repeat (5 * FT + 20) tick();
    // Mid-frame reset at a known position inside the active area.
    async_reset(3, 2);
    repeat (2 * HT + 5) tick();
    async_reset(4, 3);
    repeat (FT + 7) tick();
    // Random run lengths, reset offsets and hold times.
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 300);
      repeat (n) tick();
      async_reset($urandom_range(0, 5), $urandom_range(1, 3));
    end
    repeat (2 * FT) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
